// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel byte handshake plus serial line and status for uart_tx
interface uart_tx_if;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       pi_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;
  logic       drop_err;
  modport master (output pi_data, pi_flag, input pi_ready, tx, tx_busy, tx_done, drop_err);
  modport slave (input pi_data, pi_flag, output pi_ready, tx, tx_busy, tx_done, drop_err);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit, no-parity UART transmitter (1 or 2 stop bits) with a one-deep holding register
module uart_tx #(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int STOP_BITS = 1
) (
  input logic      sys_clk,
  input logic      sys_rst,
  uart_tx_if.slave bus
);
  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BAUD_CNT_MAX) > 0 ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(BAUD_CNT_MAX - 2);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_hold;
  logic          r_hold_valid;
  logic          r_tx;
  logic          r_done;
  logic          r_drop;
  logic          w_bit_end;
  logic          w_last_stop;
  logic          w_launch_pt;
  logic          w_launch;
  assign w_bit_end   = r_baud_cnt == BAUD_LAST;
  assign w_last_stop = r_state == STOP && r_stop_cnt == STOP_LAST;
  assign w_launch_pt = r_state == IDLE || (w_last_stop && w_bit_end);
  assign w_launch    = w_launch_pt && (r_hold_valid || bus.pi_flag);
  assign bus.pi_ready = ~r_hold_valid;
  assign bus.tx       = r_tx;
  assign bus.tx_busy  = r_state != IDLE;
  assign bus.tx_done  = r_done;
  assign bus.drop_err = r_drop;
  // Frame sequencer: launch at L (idle or last stop cycle), then one baud period per start/data/stop bit
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last_stop && r_baud_cnt == BAUD_PRE;
      if (w_launch) begin
        r_state    <= START;
        r_baud_cnt <= '0;
        r_bit_cnt  <= '0;
        r_stop_cnt <= 1'b0;
        r_shift    <= r_hold_valid ? r_hold : bus.pi_data;
        r_tx       <= 1'b0;
      end else if (w_launch_pt) begin
        r_state    <= IDLE;
        r_baud_cnt <= '0;
        r_tx       <= 1'b1;
      end else begin
        r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
        if (w_bit_end)
          case (r_state)
            START: begin
              r_state <= DATA;
              r_tx    <= r_shift[0];
            end
            DATA:
              if (r_bit_cnt == 3'd7) begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end else begin
                r_shift   <= r_shift >> 1;
                r_tx      <= r_shift[1];
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            default: r_stop_cnt <= r_stop_cnt + 1'b1;
          endcase
      end
    end
  // Holding register: fills when empty unless the byte bypasses at L; a flag while full is dropped
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_drop <= bus.pi_flag && r_hold_valid;
      if (w_launch_pt && r_hold_valid)
        r_hold_valid <= 1'b0;
      else if (bus.pi_flag && !r_hold_valid && !w_launch_pt) begin
        r_hold_valid <= 1'b1;
        r_hold       <= bus.pi_data;
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and loopback checks for uart_tx at 10 clocks per bit
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int err = 0;
  always #5 clk = ~clk;
  uart_tx_if b1 ();
  uart_tx_if b2 ();
  uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .STOP_BITS(1)) dut1 (.sys_clk(clk), .sys_rst(rst), .bus(b1));
  uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .STOP_BITS(2)) dut2 (.sys_clk(clk), .sys_rst(rst), .bus(b2));
  logic       rx_en = 1'b0;
  int         rx_cnt = -1;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  // loopback receiver: mid-bit sampling of b1.tx after a falling start edge
  initial forever begin
    @(negedge clk);
    if (rx_en) begin
      if (rx_cnt < 0) begin
        if (b1.tx === 1'b0) rx_cnt = 0;
      end else begin
        rx_cnt++;
        if (rx_cnt >= 15 && rx_cnt <= 85 && rx_cnt % 10 == 5) rx_sh = {b1.tx, rx_sh[7:1]};
        if (rx_cnt == 95) begin
          vec++;
          if (b1.tx !== 1'b1) begin err++; $display("FAIL rx_stop: tx=%b required 1", b1.tx); end
          rx_q.push_back(rx_sh);
          rx_cnt = -1;
        end
      end
    end
  end
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    return k < 10 ? 1'b0 : k < 90 ? b[(k - 10) / 10] : 1'b1;
  endfunction
  task automatic launch1(input logic [7:0] d);
    @(posedge clk); #1;
    b1.pi_data = d;
    b1.pi_flag = 1'b1;
    @(posedge clk); #1;
    b1.pi_flag = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      vec++;
      if ({b1.tx, b1.tx_busy, b1.pi_ready, b1.tx_done, b1.drop_err, b2.tx, b2.tx_busy, b2.pi_ready, b2.tx_done, b2.drop_err} !== 10'b10100_10100) begin
        err++;
        $display("FAIL reset_idle k=%0d: tx/busy/ready/done/drop x2=%b required 1010010100", k,
                 {b1.tx, b1.tx_busy, b1.pi_ready, b1.tx_done, b1.drop_err, b2.tx, b2.tx_busy, b2.pi_ready, b2.tx_done, b2.drop_err});
      end
    end
  endtask
  task automatic test_single;
    logic [9:0] seq;
    seq = 10'b11_0100_1010;
    launch1(8'hA5);
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      vec++;
      if (b1.tx !== (k < 100 ? seq[k / 10] : 1'b1)) begin err++; $display("FAIL single_tx k=%0d: got %b", k, b1.tx); end
      vec++;
      if (b1.tx_done !== (k == 99)) begin err++; $display("FAIL single_done k=%0d: got %b required %b", k, b1.tx_done, k == 99); end
      vec++;
      if (b1.tx_busy !== (k < 100)) begin err++; $display("FAIL single_busy k=%0d: got %b required %b", k, b1.tx_busy, k < 100); end
    end
  endtask
  task automatic test_back_to_back;
    logic e;
    launch1(8'h3C);
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      e = k < 100 ? exp_tx(8'h3C, k) : k < 200 ? exp_tx(8'hC3, k - 100) : 1'b1;
      vec++;
      if (b1.tx !== e) begin err++; $display("FAIL b2b_tx k=%0d: got %b required %b", k, b1.tx, e); end
      vec++;
      if (b1.pi_ready !== !(k >= 20 && k < 100)) begin err++; $display("FAIL b2b_ready k=%0d: got %b", k, b1.pi_ready); end
      vec++;
      if (b1.tx_done !== (k == 99 || k == 199)) begin err++; $display("FAIL b2b_done k=%0d: got %b", k, b1.tx_done); end
      vec++;
      if (b1.tx_busy !== (k < 200)) begin err++; $display("FAIL b2b_busy k=%0d: got %b", k, b1.tx_busy); end
      b1.pi_flag = (k == 19);
      b1.pi_data = 8'hC3;
    end
  endtask
  task automatic test_drop;
    logic e;
    launch1(8'h5A);
    for (int k = 0; k < 210; k++) begin
      @(negedge clk);
      e = k < 100 ? exp_tx(8'h5A, k) : k < 200 ? exp_tx(8'h96, k - 100) : 1'b1;
      vec++;
      if (b1.tx !== e) begin err++; $display("FAIL drop_tx k=%0d: got %b required %b", k, b1.tx, e); end
      vec++;
      if (b1.drop_err !== (k == 30)) begin err++; $display("FAIL drop_err k=%0d: got %b required %b", k, b1.drop_err, k == 30); end
      vec++;
      if (b1.pi_ready !== !(k >= 5 && k < 100)) begin err++; $display("FAIL drop_ready k=%0d: got %b", k, b1.pi_ready); end
      b1.pi_flag = (k == 4 || k == 29);
      b1.pi_data = k == 29 ? 8'hFF : 8'h96;
    end
  endtask
  task automatic test_two_stop;
    @(posedge clk); #1;
    b2.pi_data = 8'h00;
    b2.pi_flag = 1'b1;
    @(posedge clk); #1;
    b2.pi_flag = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      vec++;
      if (b2.tx !== (k >= 90)) begin err++; $display("FAIL stop2_tx k=%0d: got %b required %b", k, b2.tx, k >= 90); end
      vec++;
      if (b2.tx_done !== (k == 109)) begin err++; $display("FAIL stop2_done k=%0d: got %b required %b", k, b2.tx_done, k == 109); end
      vec++;
      if (b2.tx_busy !== (k < 110)) begin err++; $display("FAIL stop2_busy k=%0d: got %b required %b", k, b2.tx_busy, k < 110); end
    end
  endtask
  task automatic test_reset_mid;
    launch1(8'h00);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      b1.pi_flag = (k == 4);
      b1.pi_data = 8'h77;
    end
    vec++;
    if (b1.tx !== 1'b0) begin err++; $display("FAIL mid_pre: tx=%b required 0", b1.tx); end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({b1.tx, b1.tx_busy, b1.pi_ready} !== 3'b101) begin err++; $display("FAIL mid_async: tx/busy/ready=%b required 101", {b1.tx, b1.tx_busy, b1.pi_ready}); end
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      vec++;
      if ({b1.tx, b1.tx_busy, b1.pi_ready} !== 3'b101) begin err++; $display("FAIL mid_after k=%0d: tx/busy/ready=%b required 101", k, {b1.tx, b1.tx_busy, b1.pi_ready}); end
    end
  endtask
  task automatic test_stream;
    int sent = 0;
    int drops = 0;
    int pulses = 0;
    int guard = 0;
    logic [7:0] exp_q[$];
    rx_en = 1'b1;
    while (sent < 200) begin
      @(negedge clk);
      if (b1.drop_err === 1'b1) pulses++;
      b1.pi_flag = ($urandom_range(0, 19) == 0);
      if (b1.pi_flag) begin
        b1.pi_data = 8'($urandom);
        sent++;
        if (b1.pi_ready === 1'b1) exp_q.push_back(b1.pi_data);
        else drops++;
      end
    end
    @(negedge clk);
    if (b1.drop_err === 1'b1) pulses++;
    b1.pi_flag = 1'b0;
    while ((b1.tx_busy !== 1'b0 || b1.pi_ready !== 1'b1) && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    vec++;
    if (guard >= 400) begin err++; $display("FAIL stream_drain: busy=%b ready=%b after %0d cycles", b1.tx_busy, b1.pi_ready, guard); end
    repeat (20) @(negedge clk);
    rx_en = 1'b0;
    vec++;
    if (pulses !== drops) begin err++; $display("FAIL stream_drops: drop_err pulses=%0d required %0d", pulses, drops); end
    vec++;
    if (rx_q.size() !== exp_q.size()) begin err++; $display("FAIL stream_count: received %0d required %0d", rx_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      vec++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        err++;
        $display("FAIL stream_byte %0d: got %h required %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask
  initial begin
    b1.pi_flag = 1'b0;
    b1.pi_data = '0;
    b2.pi_flag = 1'b0;
    b2.pi_data = '0;
    test_reset;
    test_single;
    test_back_to_back;
    test_drop;
    test_two_stop;
    test_reset_mid;
    test_stream;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
